// File: rtl/cache_base_ctrl.sv
// ============================================================================
// Module   : cache_base_ctrl
// Purpose  : Blocking write-through, no-allocate cache controller FSM with
//            line refill. Optional macro LAB3_CACHE_HIT_FASTPATH_EN answers
//            read hits directly from TAG_CHECK.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_base_ctrl #(
    parameter int NUM_LINES      = 32,
    parameter int WORDS_PER_LINE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       memreq_val,
    output logic       memreq_rdy,
    output logic       memresp_val,
    input  logic       memresp_rdy,
    output logic       cache_req_val,
    input  logic       cache_req_rdy,
    input  logic       cache_resp_val,
    output logic       cache_resp_rdy,
    input  logic       read,
    input  logic       tag_array_match,
    input  logic [4:0] index,
    output logic       data_array_r_en,
    output logic       data_array_w_en,
    output logic       data_array_write_mux_sel,
    output logic       tag_array_w_en,
    output logic [4:0] received_mem_resp_num,
    output logic [3:0] refill_req_word,
    output logic       cache_req_is_write
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TAG_CHECK  = 3'd1,
        S_REFILL     = 3'd2,
        S_WRITE_REQ  = 3'd3,
        S_WRITE_WAIT = 3'd4,
        S_RESP       = 3'd5
    } state_t;

    localparam logic [4:0] c_WORDS = 5'(WORDS_PER_LINE);
    localparam logic [4:0] c_LAST  = 5'(WORDS_PER_LINE - 1);

    state_t                 r_state_q;
    state_t                 w_state_d;
    logic [NUM_LINES-1:0]   r_valid_q;
    logic [NUM_LINES-1:0]   w_valid_d;
    logic [4:0]             r_req_cnt_q;
    logic [4:0]             w_req_cnt_d;
    logic [4:0]             r_resp_cnt_q;
    logic [4:0]             w_resp_cnt_d;
    logic                   w_hit;

    assign w_hit = tag_array_match & r_valid_q[index];

    always_comb begin
        w_state_d                = r_state_q;
        w_valid_d                = r_valid_q;
        w_req_cnt_d              = r_req_cnt_q;
        w_resp_cnt_d             = r_resp_cnt_q;
        memreq_rdy               = 1'b0;
        memresp_val              = 1'b0;
        cache_req_val            = 1'b0;
        cache_resp_rdy           = 1'b0;
        data_array_r_en          = 1'b0;
        data_array_w_en          = 1'b0;
        data_array_write_mux_sel = 1'b0;
        tag_array_w_en           = 1'b0;
        refill_req_word          = 4'd0;
        cache_req_is_write       = 1'b0;
        received_mem_resp_num    = r_resp_cnt_q;

        case (r_state_q)
            S_IDLE: begin
                memreq_rdy = 1'b1;
                if (memreq_val) begin
                    w_state_d = S_TAG_CHECK;
                end
            end
            S_TAG_CHECK: begin
                data_array_r_en = 1'b1;
                if (read) begin
                    if (w_hit) begin
`ifdef LAB3_CACHE_HIT_FASTPATH_EN
                        memresp_val = 1'b1;
                        w_state_d   = memresp_rdy ? S_IDLE : S_RESP;
`else
                        w_state_d   = S_RESP;
`endif
                    end else begin
                        w_req_cnt_d  = 5'd0;
                        w_resp_cnt_d = 5'd0;
                        w_state_d    = S_REFILL;
                    end
                end else begin
                    // Write-through, no-allocate: only a hit updates the array
                    data_array_w_en = w_hit;
                    w_state_d       = S_WRITE_REQ;
                end
            end
            S_REFILL: begin
                cache_resp_rdy = 1'b1;
                if (r_req_cnt_q < c_WORDS) begin
                    cache_req_val   = 1'b1;
                    refill_req_word = r_req_cnt_q[3:0];
                    if (cache_req_rdy) begin
                        w_req_cnt_d = r_req_cnt_q + 5'd1;
                    end
                end
                if (cache_resp_val && (r_resp_cnt_q < c_WORDS)) begin
                    data_array_w_en          = 1'b1;
                    data_array_write_mux_sel = 1'b1;
                    w_resp_cnt_d             = r_resp_cnt_q + 5'd1;
                    if (r_resp_cnt_q == c_LAST) begin
                        tag_array_w_en   = 1'b1;
                        w_valid_d[index] = 1'b1;
                        w_state_d        = S_RESP;
                    end
                end
            end
            S_WRITE_REQ: begin
                cache_req_val      = 1'b1;
                cache_req_is_write = 1'b1;
                if (cache_req_rdy) begin
                    w_state_d = S_WRITE_WAIT;
                end
            end
            S_WRITE_WAIT: begin
                cache_resp_rdy = 1'b1;
                if (cache_resp_val) begin
                    w_state_d = S_RESP;
                end
            end
            S_RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Reset wins over any in-flight transition and presents IDLE outputs
        if (reset) begin
            w_state_d                = S_IDLE;
            w_valid_d                = '0;
            w_req_cnt_d              = 5'd0;
            w_resp_cnt_d             = 5'd0;
            memreq_rdy               = 1'b1;
            memresp_val              = 1'b0;
            cache_req_val            = 1'b0;
            cache_resp_rdy           = 1'b0;
            data_array_r_en          = 1'b0;
            data_array_w_en          = 1'b0;
            data_array_write_mux_sel = 1'b0;
            tag_array_w_en           = 1'b0;
            refill_req_word          = 4'd0;
            cache_req_is_write       = 1'b0;
            received_mem_resp_num    = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= S_IDLE;
            r_valid_q    <= '0;
            r_req_cnt_q  <= 5'd0;
            r_resp_cnt_q <= 5'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_valid_q    <= w_valid_d;
            r_req_cnt_q  <= w_req_cnt_d;
            r_resp_cnt_q <= w_resp_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_base_ctrl.sv
// ============================================================================
// Module   : tb_cache_base_ctrl
// Purpose  : Directed, self-checking bench for cache_base_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cache_base_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       memreq_val;
    logic       memreq_rdy;
    logic       memresp_val;
    logic       memresp_rdy;
    logic       cache_req_val;
    logic       cache_req_rdy;
    logic       cache_resp_val;
    logic       cache_resp_rdy;
    logic       read;
    logic       tag_array_match;
    logic [4:0] index;
    logic       data_array_r_en;
    logic       data_array_w_en;
    logic       data_array_write_mux_sel;
    logic       tag_array_w_en;
    logic [4:0] received_mem_resp_num;
    logic [3:0] refill_req_word;
    logic       cache_req_is_write;
    logic [8:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_base_ctrl #(.NUM_LINES(32), .WORDS_PER_LINE(16)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .memreq_val               (memreq_val),
        .memreq_rdy               (memreq_rdy),
        .memresp_val              (memresp_val),
        .memresp_rdy              (memresp_rdy),
        .cache_req_val            (cache_req_val),
        .cache_req_rdy            (cache_req_rdy),
        .cache_resp_val           (cache_resp_val),
        .cache_resp_rdy           (cache_resp_rdy),
        .read                     (read),
        .tag_array_match          (tag_array_match),
        .index                    (index),
        .data_array_r_en          (data_array_r_en),
        .data_array_w_en          (data_array_w_en),
        .data_array_write_mux_sel (data_array_write_mux_sel),
        .tag_array_w_en           (tag_array_w_en),
        .received_mem_resp_num    (received_mem_resp_num),
        .refill_req_word          (refill_req_word),
        .cache_req_is_write       (cache_req_is_write)
    );

    // {memreq_rdy, memresp_val, cache_req_val, cache_resp_rdy, r_en, w_en, mux_sel, tag_w_en, is_write}
    assign outs = {memreq_rdy, memresp_val, cache_req_val, cache_resp_rdy, data_array_r_en,
                   data_array_w_en, data_array_write_mux_sel, tag_array_w_en, cache_req_is_write};

    localparam logic [8:0] c_O_IDLE = 9'b100000000;
    localparam logic [8:0] c_O_TCHK = 9'b000010000;
    localparam logic [8:0] c_O_THIT = 9'b000011000;
    localparam logic [8:0] c_O_WREQ = 9'b001000001;
    localparam logic [8:0] c_O_WWT  = 9'b000100000;
    localparam logic [8:0] c_O_RESP = 9'b010000000;

    typedef struct {
        logic       mreq_val;
        logic       rd;
        logic       match;
        logic [4:0] idx;
        logic       creq_rdy;
        logic       cresp_val;
        logic       mresp_rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vtab [21];

    function automatic vec_t mk(input logic mv, input logic rd, input logic mt, input logic [4:0] ix,
                                input logic cr, input logic cv, input logic mr, input logic [8:0] e);
        vec_t v;
        v.mreq_val = mv; v.rd = rd; v.match = mt; v.idx = ix;
        v.creq_rdy = cr; v.cresp_val = cv; v.mresp_rdy = mr; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        memreq_val = 1'b0; memresp_rdy = 1'b0; cache_req_rdy = 1'b0;
        cache_resp_val = 1'b0; read = 1'b0; tag_array_match = 1'b0; index = 5'd0;
    endtask

    // Read miss with a one-cycle-latency memory model; optional ready toggling,
    // a processor stall of 'hold' cycles, or a reset after 'abort_at' fills.
    task automatic run_refill(input logic [4:0] ix, input bit toggle, input int hold, input int abort_at);
        int  nreq, nwr, ntag, pending;
        bit  done;
        nreq = 0; nwr = 0; ntag = 0; pending = 0; done = 1'b0;
        @(negedge clk);
        idle_inputs();
        memreq_val = 1'b1; read = 1'b1; index = ix;
        #1 chk("accept_rdy", {31'd0, memreq_rdy}, 1);
        @(negedge clk);
        memreq_val = 1'b0;
        #1 chk("miss_tagcheck", {23'd0, outs}, {23'd0, c_O_TCHK});
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            cache_req_rdy  = toggle ? cyc[0] : 1'b1;
            cache_resp_val = (pending > 0);
            #1;
            if (memresp_val) begin
                done = 1'b1;
            end else begin
                chk("refill_cnt", {27'd0, received_mem_resp_num}, nwr);
                if (cache_req_val) begin
                    chk("req_word", {28'd0, refill_req_word}, {28'd0, nreq[3:0]});
                    chk("req_is_rd", {31'd0, cache_req_is_write}, 0);
                    if (cache_req_rdy) begin
                        nreq++;
                        pending++;
                    end
                end
                if (cache_resp_val && cache_resp_rdy) begin
                    chk("fill_wr", {30'd0, data_array_w_en, data_array_write_mux_sel}, 3);
                    pending--;
                    nwr++;
                end
                if (tag_array_w_en) ntag++;
                if (abort_at > 0 && nwr == abort_at) begin
                    @(negedge clk);
                    reset = 1'b1; cache_resp_val = 1'b0; cache_req_rdy = 1'b0;
                    #1 chk("rst_cycle_outs", {23'd0, outs}, {23'd0, c_O_IDLE});
                    @(negedge clk);
                    reset = 1'b0;
                    #1;
                    chk("rst_cnt_clear", {27'd0, received_mem_resp_num}, 0);
                    chk("rst_idle_outs", {23'd0, outs}, {23'd0, c_O_IDLE});
                    return;
                end
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL refill_timeout: got no memresp_val expected memresp_val within 200 cycles");
            return;
        end
        cache_req_rdy = 1'b0; cache_resp_val = 1'b0;
        chk("n_requests", nreq, 16);
        chk("n_fills", nwr, 16);
        chk("n_tag_writes", ntag, 1);
        chk("final_cnt", {27'd0, received_mem_resp_num}, 16);
        for (int h = 0; h < hold; h++) begin
            chk("resp_hold", {23'd0, outs}, {23'd0, c_O_RESP});
            @(negedge clk);
            #1;
        end
        memresp_rdy = 1'b1;
        #1 chk("resp_out", {23'd0, outs}, {23'd0, c_O_RESP});
        @(negedge clk);
        memresp_rdy = 1'b0;
        #1 chk("back_idle", {23'd0, outs}, {23'd0, c_O_IDLE});
    endtask

    initial begin
        // Write hit on line 3 (valid after the first refill)
        vtab[0]  = mk(1, 0, 1, 5'd3, 0, 0, 0, c_O_IDLE);
        vtab[1]  = mk(0, 0, 1, 5'd3, 0, 0, 0, c_O_THIT);
        vtab[2]  = mk(0, 0, 1, 5'd3, 0, 1, 0, c_O_WREQ);
        vtab[3]  = mk(0, 0, 1, 5'd3, 1, 0, 0, c_O_WREQ);
        vtab[4]  = mk(0, 0, 1, 5'd3, 0, 0, 0, c_O_WWT);
        vtab[5]  = mk(0, 0, 1, 5'd3, 0, 1, 0, c_O_WWT);
        vtab[6]  = mk(0, 0, 1, 5'd3, 0, 0, 0, c_O_RESP);
        vtab[7]  = mk(1, 0, 1, 5'd3, 0, 0, 1, c_O_RESP);
        vtab[8]  = mk(0, 0, 0, 5'd3, 0, 0, 0, c_O_IDLE);
        // Write miss on line 7, stray memory response in IDLE
        vtab[9]  = mk(1, 0, 0, 5'd7, 0, 0, 0, c_O_IDLE);
        vtab[10] = mk(0, 0, 0, 5'd7, 0, 0, 0, c_O_TCHK);
        vtab[11] = mk(0, 0, 0, 5'd7, 1, 0, 0, c_O_WREQ);
        vtab[12] = mk(0, 0, 0, 5'd7, 0, 1, 0, c_O_WWT);
        vtab[13] = mk(0, 0, 0, 5'd7, 0, 0, 1, c_O_RESP);
        vtab[14] = mk(0, 0, 0, 5'd7, 0, 1, 0, c_O_IDLE);
        // Tag match on line 7 must still miss: it was never allocated
        vtab[15] = mk(1, 0, 1, 5'd7, 0, 0, 0, c_O_IDLE);
        vtab[16] = mk(0, 0, 1, 5'd7, 0, 0, 0, c_O_TCHK);
        vtab[17] = mk(0, 0, 1, 5'd7, 1, 0, 0, c_O_WREQ);
        vtab[18] = mk(0, 0, 1, 5'd7, 0, 1, 0, c_O_WWT);
        vtab[19] = mk(0, 0, 1, 5'd7, 0, 0, 1, c_O_RESP);
        vtab[20] = mk(0, 0, 0, 5'd7, 0, 0, 0, c_O_IDLE);

        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_outs", {23'd0, outs}, {23'd0, c_O_IDLE});
        chk("reset_cnt", {27'd0, received_mem_resp_num}, 0);
        chk("reset_word", {28'd0, refill_req_word}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_reset_idle", {23'd0, outs}, {23'd0, c_O_IDLE});

        run_refill(5'd3, 1'b0, 0, 0);

        // Read hit on line 3: no memory traffic
        @(negedge clk);
        idle_inputs();
        memreq_val = 1'b1; read = 1'b1; tag_array_match = 1'b1; index = 5'd3; memresp_rdy = 1'b1;
        #1 chk("hit_accept", {31'd0, memreq_rdy}, 1);
        @(negedge clk);
        memreq_val = 1'b0;
        #1;
`ifdef LAB3_CACHE_HIT_FASTPATH_EN
        chk("hit_tagcheck", {23'd0, outs}, {23'd0, 9'b010010000});
`else
        chk("hit_tagcheck", {23'd0, outs}, {23'd0, c_O_TCHK});
        @(negedge clk);
        #1 chk("hit_resp", {23'd0, outs}, {23'd0, c_O_RESP});
`endif
        @(negedge clk);
        memresp_rdy = 1'b0;
        #1 chk("hit_done_idle", {23'd0, outs}, {23'd0, c_O_IDLE});

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            memreq_val      = vtab[i].mreq_val;
            read            = vtab[i].rd;
            tag_array_match = vtab[i].match;
            index           = vtab[i].idx;
            cache_req_rdy   = vtab[i].creq_rdy;
            cache_resp_val  = vtab[i].cresp_val;
            memresp_rdy     = vtab[i].mresp_rdy;
            #1 chk($sformatf("vec%0d", i), {23'd0, outs}, {23'd0, vtab[i].exp});
        end

        run_refill(5'd9, 1'b1, 5, 0);

        run_refill(5'd5, 1'b0, 0, 9);

        // Line 5 was left partially filled; a matching tag must still miss
        @(negedge clk);
        idle_inputs();
        memreq_val = 1'b1; read = 1'b1; tag_array_match = 1'b1; index = 5'd5;
        #1 chk("aborted_accept", {31'd0, memreq_rdy}, 1);
        @(negedge clk);
        memreq_val = 1'b0;
        #1 chk("aborted_line_miss", {23'd0, outs}, {23'd0, c_O_TCHK});
        @(negedge clk);
        cache_req_rdy = 1'b0;
        #1;
        chk("aborted_refill_req", {31'd0, cache_req_val}, 1);
        chk("aborted_refill_cnt", {27'd0, received_mem_resp_num}, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("final_idle", {23'd0, outs}, {23'd0, c_O_IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
